// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode/state types and constants for the ALU serial datapath
package alu_pkg;
    typedef enum logic [2:0] {
        and_op = 3'b000,
        or_op  = 3'b001,
        add_op = 3'b100,
        sub_op = 3'b101
    } operation_t;

    typedef enum logic [1:0] {IDLE, FRAME, GAP, RESYNC} rx_state_t;

    localparam int ERR_DATA = 2;
    localparam int ERR_CRC  = 1;
    localparam int ERR_OP   = 0;

    localparam logic [3:0] CRC4_POLY = 4'h3;

    function automatic logic op_valid(input logic [2:0] op);
        return op inside {and_op, or_op, add_op, sub_op};
    endfunction
endpackage

// File: rtl/crc4_serial.sv
// crc4_serial: bit-serial CRC4 LFSR, MSB first, zero initial value
module crc4_serial
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       d,
    output logic [3:0] crc
);
    always_ff @(posedge clk) begin
        if (rst || clr)
            crc <= '0;
        else if (en)
            crc <= {crc[2:0], 1'b0} ^ ((crc[3] ^ d) ? CRC4_POLY : 4'h0);
    end
endmodule

// File: rtl/alu_serial_rx.sv
// alu_serial_rx: deserialises B/A operand frames and a command frame, checks
// frame count, CRC4, opcode and framing, and reports with a one-cycle pulse
module alu_serial_rx
    import alu_pkg::*;
#(
    parameter int OPW     = 32,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           sin,
    output logic           out_valid,
    output logic [OPW-1:0] b,
    output logic [OPW-1:0] a,
    output logic [2:0]     op,
    output logic [2:0]     err_flags
);
    localparam int NB = 2 * OPW / 8;
    localparam int CW = $clog2(NB + 2);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] ST_IDLE   = 2'(IDLE);
    localparam logic [1:0] ST_FRAME  = 2'(FRAME);
    localparam logic [1:0] ST_GAP    = 2'(GAP);
    localparam logic [1:0] ST_RESYNC = 2'(RESYNC);

    logic [1:0]       state;
    logic [3:0]       bit_cnt;
    logic             is_cmd;
    logic [6:0]       pay;
    logic [2*OPW-1:0] ba;
    logic [CW-1:0]    cnt;
    logic [TW-1:0]    idle;
    logic [3:0]       crc;
    logic             in_frame, payload, take, crc_en, crc_d, stop, timeout, report;
    logic [2:0]       err;

    // bit_cnt is the index of the bit the next edge samples: 1 type, 2..9 payload, 10 stop
    always_comb begin
        in_frame = state == ST_FRAME;
        payload  = in_frame && bit_cnt >= 4'd2 && bit_cnt <= 4'd9;
        take     = payload && !is_cmd && cnt < CW'(NB);
        crc_en   = take || (payload && is_cmd && bit_cnt <= 4'd5);
        crc_d    = (is_cmd && bit_cnt == 4'd2) ? 1'b1 : sin;
        stop     = in_frame && bit_cnt == 4'd10;
        timeout  = state == ST_GAP && sin && idle == TW'(TIMEOUT - 1);
        report   = (stop && (is_cmd || !sin)) || timeout;
        err      = (!stop || !sin || cnt != CW'(NB)) ? 3'(1 << ERR_DATA) :
                   (crc != pay[3:0])                 ? 3'(1 << ERR_CRC)  :
                   !op_valid(pay[6:4])               ? 3'(1 << ERR_OP)   : 3'b000;
    end

    crc4_serial u_crc (
        .clk(clk),
        .rst(rst),
        .clr(report),
        .en(crc_en),
        .d(crc_d),
        .crc(crc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            is_cmd  <= 1'b0;
            pay     <= '0;
            ba      <= '0;
            cnt     <= '0;
            idle    <= '0;
        end else begin
            bit_cnt <= (in_frame && !stop) ? bit_cnt + 4'd1 : 4'd1;
            if (in_frame && bit_cnt == 4'd1)
                is_cmd <= sin;
            if (payload)
                pay <= {pay[5:0], sin};
            if (take)
                ba <= {ba[2*OPW-2:0], sin};
            if (report)
                cnt <= '0;
            else if (stop && !is_cmd && cnt != CW'(NB + 1))
                cnt <= cnt + CW'(1);
            idle <= (state == ST_GAP) ? idle + TW'(1) : '0;
            case (state)
                ST_IDLE:  if (!sin) state <= ST_FRAME;
                ST_FRAME: if (stop) state <= !sin ? ST_RESYNC : is_cmd ? ST_IDLE : ST_GAP;
                ST_GAP:   state <= !sin ? ST_FRAME : timeout ? ST_IDLE : ST_GAP;
                default:  if (sin) state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            b         <= '0;
            a         <= '0;
            op        <= '0;
            err_flags <= '0;
        end else begin
            out_valid <= report;
            if (report) begin
                err_flags <= err;
                {b, a}    <= err[ERR_DATA] ? '0 : ba;
                op        <= err[ERR_DATA] ? 3'b000 : pay[6:4];
            end
        end
    end
endmodule
